registerfile_param: RTL and testbench
=====================================

// Module: registerfile_param
// PURPOSE
//   Parametrised register file for the pipeline's decode/writeback stages: 2 combinational read
//   ports, 1 rising-edge write port with byte mask, write-to-read bypass, hardwired zero register,
//   and a pending-write scoreboard. Decode uses the busy flags to detect RAW hazards.
// PARAMETERS
//   DATA_W      32  register width in bits; multiple of 8
//   ADDR_W      5   address width; depth = 2**ADDR_W
//   ZERO_REG    1   1: register 0 reads 0, ignores writes and claims; 0: register 0 is ordinary
//   BYPASS      1   1: same-cycle write data forwarded to read ports; 0: read returns stored value
// PORTS
//   clk            in   1         clock; all state updates on rising edge
//   rst            in   1         asynchronous active-high reset
//   reg1addr       in   ADDR_W    read port 1 address
//   reg2addr       in   ADDR_W    read port 2 address
//   reg1content    out  DATA_W    read port 1 data (combinational)
//   reg2content    out  DATA_W    read port 2 data (combinational)
//   reg1busy       out  1         read port 1 register has an outstanding claim
//   reg2busy       out  1         read port 2 register has an outstanding claim
//   regWrite       in   1         write enable
//   writeRegister  in   ADDR_W    write address
//   writeData      in   DATA_W    write data
//   writeMask      in   DATA_W/8  byte enables; bit i covers writeData[8i+7:8i]
//   claimEn        in   1         mark claimAddr as pending a future write
//   claimAddr      in   ADDR_W    register being claimed by an issuing instruction
// BEHAVIOUR
//   Reset: rst=1 asynchronously clears every register and every pending bit. While rst=1, and
//     after release until the first write, reg*content=0 and reg*busy=0.
//   Write: on posedge clk with regWrite=1, the bytes of registers[writeRegister] enabled in
//     writeMask take writeData; other bytes are kept. writeMask=0 leaves the data unchanged but
//     still clears the pending bit. Write takes effect at the edge.
//   Read: reg*content = registers[reg*addr], combinational, zero latency. With BYPASS=1 and
//     regWrite=1 and reg*addr==writeRegister (and not the zero register), the output is the merged
//     value: writeData bytes where the mask is set, stored bytes elsewhere.
//   Zero register (ZERO_REG=1): address 0 always reads 0, never busy. Writes and claims to it are
//     dropped. It is never bypassed.
//   Scoreboard: one pending bit per register.
//     - Posedge with regWrite=1 clears pending[writeRegister].
//     - Posedge with claimEn=1 sets pending[claimAddr].
//     - Same edge, same address, both active: set wins (new claim outstanding after old writeback).
//     - Claim of an already-pending register: stays set (no counting; one writer in flight per reg).
//   Busy: reg*busy = pending[reg*addr].
//     - With BYPASS=1, forced 0 when the same cycle's write targets reg*addr, because data is
//       forwarded.
//     - With BYPASS=0, busy follows pending only.
//   Both read ports may address the same register, including the write target; each resolves
//     independently.
//   Reset asserted mid-operation discards any same-cycle write or claim. No X propagates from
//     unwritten registers (reset defines all entries).
// TESTING
//   1 reset, then read all 32 addrs on both ports -> all 0, busy=0
//   2 write r8=0x00000002 mask=4'hF, next cycle read reg1addr=8 -> 0x00000002; write r0=0xFFFFFFFF
//     -> r0 reads 0
//   3 r9=0x11223344; same cycle write r9 0xAABBCCDD mask=4'b0101 with reg2addr=9 -> reg2content
//     0x11BB33DD (BYPASS=1) / 0x11223344 (BYPASS=0); next cycle 0x11BB33DD both
//   4 claim r10 -> reg1busy=1 at addr 10; writeback r10=10 -> busy=0 in the write cycle (BYPASS=1),
//     pending cleared after the edge
//   5 same edge claimEn r11 and regWrite r11=5 -> after edge r11=5, reg1busy=1
//   6 assert rst between clock edges with r12=132 pending -> immediately content=0, busy=0;
//     write on the reset edge dropped

Source files
------------

// File: rtl/registerfile_param_if.sv
// Register file bus: two read ports with busy flags, one masked write port,
// and a claim port that marks a register as pending a future writeback.
//   reg1addr/reg2addr       read addresses          (master -> slave)
//   reg1content/reg2content combinational read data (slave -> master)
//   reg1busy/reg2busy       outstanding-claim flags (slave -> master)
//   regWrite/writeRegister/writeData/writeMask      write port
//   claimEn/claimAddr                               claim port
interface registerfile_param_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic [ADDR_W-1:0]     reg1addr;
  logic [ADDR_W-1:0]     reg2addr;
  logic [DATA_W-1:0]     reg1content;
  logic [DATA_W-1:0]     reg2content;
  logic                  reg1busy;
  logic                  reg2busy;
  logic                  regWrite;
  logic [ADDR_W-1:0]     writeRegister;
  logic [DATA_W-1:0]     writeData;
  logic [DATA_W/8-1:0]   writeMask;
  logic                  claimEn;
  logic [ADDR_W-1:0]     claimAddr;

  modport master (
    output reg1addr, reg2addr, regWrite, writeRegister, writeData, writeMask,
           claimEn, claimAddr,
    input  reg1content, reg2content, reg1busy, reg2busy
  );

  modport slave (
    input  reg1addr, reg2addr, regWrite, writeRegister, writeData, writeMask,
           claimEn, claimAddr,
    output reg1content, reg2content, reg1busy, reg2busy
  );
endinterface

// File: rtl/registerfile_param.sv
// Parametrised register file: 2 combinational read ports, 1 byte-masked write
// port, optional write-to-read bypass, optional hardwired zero register and a
// per-register pending-write scoreboard used by decode for RAW detection.
//   clk  clock, all state updates on the rising edge
//   rst  asynchronous active-high reset, clears data and pending bits
//   rf   register file bus (slave side)
module registerfile_param #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  registerfile_param_if.slave rf
);
  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned NBYTES = DATA_W / 8;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  pending_q;
  logic [DEPTH-1:0]  pending_d;
  logic [DATA_W-1:0] wr_data_d;
  logic [DATA_W-1:0] wr_bitmask;
  logic              wr_ok;
  logic              claim_ok;
  logic              hit1;
  logic              hit2;
  logic              zero1;
  logic              zero2;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  // Expand byte enables into a bit mask.
  for (genvar b = 0; b < NBYTES; b++) begin : g_mask
    assign wr_bitmask[8*b +: 8] = {8{rf.writeMask[b]}};
  end

  // Writes and claims are dropped during reset and when aimed at the zero register.
  always_comb begin
    wr_ok     = rf.regWrite && !rst && !is_zero(rf.writeRegister);
    claim_ok  = rf.claimEn && !rst && !is_zero(rf.claimAddr);
    wr_data_d = (rf.writeData & wr_bitmask) | (regs_q[rf.writeRegister] & ~wr_bitmask);
  end

  // Scoreboard: writeback clears, claim sets; a claim on the same edge wins.
  always_comb begin
    pending_d = pending_q;
    if (wr_ok) pending_d[rf.writeRegister] = 1'b0;
    if (claim_ok) pending_d[rf.claimAddr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q    <= '{default: '0};
      pending_q <= '0;
    end else begin
      if (wr_ok) regs_q[rf.writeRegister] <= wr_data_d;
      pending_q <= pending_d;
    end
  end

  // Read ports resolve independently; a bypassed register is not busy since its data is forwarded.
  always_comb begin
    zero1 = is_zero(rf.reg1addr);
    zero2 = is_zero(rf.reg2addr);
    hit1  = BYPASS && wr_ok && (rf.reg1addr == rf.writeRegister);
    hit2  = BYPASS && wr_ok && (rf.reg2addr == rf.writeRegister);
  end

  assign rf.reg1content = zero1 ? '0 : (hit1 ? wr_data_d : regs_q[rf.reg1addr]);
  assign rf.reg2content = zero2 ? '0 : (hit2 ? wr_data_d : regs_q[rf.reg2addr]);
  assign rf.reg1busy    = !zero1 && !hit1 && pending_q[rf.reg1addr];
  assign rf.reg2busy    = !zero2 && !hit2 && pending_q[rf.reg2addr];
endmodule

// File: tb/tb_registerfile_param.sv
// Directed bench for registerfile_param (DATA_W=32, ADDR_W=5, ZERO_REG=1, BYPASS=1).
// Expected read results are queued as stimulus is applied and drained against the DUT.
module tb_registerfile_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  typedef struct {
    string       tag;
    int          port;
    logic [31:0] data;
    logic        busy;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  registerfile_param_if #(.DATA_W(32), .ADDR_W(5)) rf_bus ();

  registerfile_param #(
    .DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rf (rf_bus)
  );

  task automatic idle();
    rf_bus.regWrite      = 1'b0;
    rf_bus.writeRegister = '0;
    rf_bus.writeData     = '0;
    rf_bus.writeMask     = '0;
    rf_bus.claimEn       = 1'b0;
    rf_bus.claimAddr     = '0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] m);
    rf_bus.regWrite      = 1'b1;
    rf_bus.writeRegister = a;
    rf_bus.writeData     = d;
    rf_bus.writeMask     = m;
  endtask

  task automatic claim(input logic [4:0] a);
    rf_bus.claimEn   = 1'b1;
    rf_bus.claimAddr = a;
  endtask

  task automatic exp_rd(input string tag, input int port, input logic [31:0] d, input logic b);
    exp_t e;
    e.tag = tag; e.port = port; e.data = d; e.busy = b;
    sb.push_back(e);
  endtask

  // Let combinational reads settle, then compare every queued expectation.
  task automatic check_sb();
    exp_t        e;
    logic [31:0] od;
    logic        ob;
    #1;
    while (sb.size() > 0) begin
      e  = sb.pop_front();
      od = (e.port == 1) ? rf_bus.reg1content : rf_bus.reg2content;
      ob = (e.port == 1) ? rf_bus.reg1busy    : rf_bus.reg2busy;
      n_assert++;
      assert (od === e.data) else begin
        n_fail++;
        $error("FAIL %s data p%0d: observed %h expected %h", e.tag, e.port, od, e.data);
      end
      n_assert++;
      assert (ob === e.busy) else begin
        n_fail++;
        $error("FAIL %s busy p%0d: observed %b expected %b", e.tag, e.port, ob, e.busy);
      end
    end
  endtask

  initial begin
    idle();
    rf_bus.reg1addr = 5'd8;
    rf_bus.reg2addr = 5'd31;
    #2;
    exp_rd("in_reset", 1, 32'h0, 1'b0);
    exp_rd("in_reset", 2, 32'h0, 1'b0);
    check_sb();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 1: every address reads zero and not busy after reset
    for (int a = 0; a < 32; a++) begin
      rf_bus.reg1addr = 5'(a);
      rf_bus.reg2addr = 5'(31 - a);
      exp_rd("reset_all", 1, 32'h0, 1'b0);
      exp_rd("reset_all", 2, 32'h0, 1'b0);
      check_sb();
    end

    // 2: plain write with bypass, then stored value; zero register ignores writes
    @(negedge clk);
    wr(5'd8, 32'h0000_0002, 4'hF);
    rf_bus.reg1addr = 5'd8;
    exp_rd("w8_bypass", 1, 32'h0000_0002, 1'b0);
    check_sb();
    @(negedge clk);
    idle();
    exp_rd("w8_stored", 1, 32'h0000_0002, 1'b0);
    check_sb();
    @(negedge clk);
    wr(5'd0, 32'hFFFF_FFFF, 4'hF);
    rf_bus.reg1addr = 5'd0;
    rf_bus.reg2addr = 5'd0;
    exp_rd("w0_nobypass", 1, 32'h0, 1'b0);
    exp_rd("w0_nobypass", 2, 32'h0, 1'b0);
    check_sb();
    @(negedge clk);
    idle();
    exp_rd("w0_stored", 1, 32'h0, 1'b0);
    check_sb();

    // 3: byte-masked write merged on the bypass path, on both ports
    @(negedge clk);
    wr(5'd9, 32'h1122_3344, 4'hF);
    @(negedge clk);
    wr(5'd9, 32'hAABB_CCDD, 4'b0101);
    rf_bus.reg1addr = 5'd9;
    rf_bus.reg2addr = 5'd9;
    exp_rd("mask_bypass", 1, 32'h11BB_33DD, 1'b0);
    exp_rd("mask_bypass", 2, 32'h11BB_33DD, 1'b0);
    check_sb();
    @(negedge clk);
    idle();
    exp_rd("mask_stored", 1, 32'h11BB_33DD, 1'b0);
    exp_rd("mask_stored", 2, 32'h11BB_33DD, 1'b0);
    check_sb();

    // 4: claim sets busy after the edge; writeback hides busy in its cycle and clears it
    @(negedge clk);
    claim(5'd10);
    rf_bus.reg1addr = 5'd10;
    rf_bus.reg2addr = 5'd9;
    exp_rd("claim10_pre", 1, 32'h0, 1'b0);
    check_sb();
    @(negedge clk);
    idle();
    exp_rd("claim10_busy", 1, 32'h0, 1'b1);
    exp_rd("claim10_other", 2, 32'h11BB_33DD, 1'b0);
    check_sb();
    @(negedge clk);
    wr(5'd10, 32'd10, 4'hF);
    rf_bus.reg2addr = 5'd10;
    exp_rd("wb10_bypass", 1, 32'd10, 1'b0);
    exp_rd("wb10_bypass", 2, 32'd10, 1'b0);
    check_sb();
    @(negedge clk);
    idle();
    exp_rd("wb10_cleared", 1, 32'd10, 1'b0);
    check_sb();

    // 5: claim and writeback of the same register on one edge: claim wins
    @(negedge clk);
    claim(5'd11);
    wr(5'd11, 32'd5, 4'hF);
    rf_bus.reg1addr = 5'd11;
    exp_rd("cw11_cycle", 1, 32'd5, 1'b0);
    check_sb();
    @(negedge clk);
    idle();
    exp_rd("cw11_after", 1, 32'd5, 1'b1);
    check_sb();
    // repeated claim stays set; mask-0 write keeps data but clears pending
    @(negedge clk);
    claim(5'd11);
    @(negedge clk);
    idle();
    exp_rd("reclaim11", 1, 32'd5, 1'b1);
    check_sb();
    @(negedge clk);
    wr(5'd11, 32'hFFFF_FFFF, 4'h0);
    exp_rd("mask0_cycle", 1, 32'd5, 1'b0);
    check_sb();
    @(negedge clk);
    idle();
    exp_rd("mask0_after", 1, 32'd5, 1'b0);
    check_sb();
    // claim of the zero register is dropped
    @(negedge clk);
    claim(5'd0);
    @(negedge clk);
    idle();
    rf_bus.reg1addr = 5'd0;
    exp_rd("claim0", 1, 32'h0, 1'b0);
    check_sb();

    // 6: asynchronous reset mid-cycle with a pending register; write on the reset edge dropped
    @(negedge clk);
    wr(5'd12, 32'd132, 4'hF);
    @(negedge clk);
    idle();
    claim(5'd12);
    @(negedge clk);
    idle();
    rf_bus.reg1addr = 5'd12;
    rf_bus.reg2addr = 5'd9;
    exp_rd("r12_pending", 1, 32'd132, 1'b1);
    check_sb();
    #1;
    rst = 1'b1;
    exp_rd("rst_async", 1, 32'h0, 1'b0);
    exp_rd("rst_async", 2, 32'h0, 1'b0);
    check_sb();
    wr(5'd12, 32'h5555_5555, 4'hF);
    claim(5'd12);
    exp_rd("rst_wr_hidden", 1, 32'h0, 1'b0);
    check_sb();
    @(posedge clk);
    exp_rd("rst_edge", 1, 32'h0, 1'b0);
    check_sb();
    @(negedge clk);
    idle();
    rst = 1'b0;
    exp_rd("post_rst12", 1, 32'h0, 1'b0);
    exp_rd("post_rst9", 2, 32'h0, 1'b0);
    check_sb();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
